// File: rtl/vga_check_pkg.sv
// vga_check_pkg: checker state encoding, mismatch-log entry layout and default view window
package vga_check_pkg;
   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SYNC, S_CHECK, S_DONE} state_t;
   localparam int DEF_NUM_CH = 3;
   localparam int DEF_CH_WIDTH = 8;
   localparam int DEF_XY_WIDTH = 10;
   localparam int DEF_VIEW_LEFT = 160;
   localparam int DEF_VIEW_RIGHT = 480;
   localparam int DEF_VIEW_TOP = 120;
   localparam int DEF_VIEW_BOTTOM = 360;
   localparam int DEF_MAX_MISMATCHES = 10;
   localparam int DEF_CNT_WIDTH = 20;
   localparam int DEF_LOG_DEPTH = 8;
   typedef struct packed {
      logic [DEF_XY_WIDTH-1:0] y;
      logic [DEF_XY_WIDTH-1:0] x;
      logic [DEF_NUM_CH-1:0]   mask;
   } log_entry_t;
endpackage

// File: rtl/mismatch_log_fifo.sv
// mismatch_log_fifo: small FIFO of failing-pixel records, drops writes when full, registered read data
module mismatch_log_fifo #(
   parameter int WIDTH = 23,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             empty
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int UW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [UW-1:0] used;
   logic do_wr, do_rd;
   assign empty = used == '0;
   assign do_wr = wr & (used != UW'(DEPTH));
   assign do_rd = rd & ~empty;
   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction
   // pointers, fill level and read register; clear wins over any access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         used <= '0;
         rdata <= '0;
      end else if (clr) begin
         wp <= '0;
         rp <= '0;
         used <= '0;
         rdata <= '0;
      end else begin
         if (do_wr) wp <= inc(wp);
         if (do_rd) begin
            rp <= inc(rp);
            rdata <= mem[rp];
         end
         used <= used + UW'(do_wr) - UW'(do_rd);
      end
   end
   // storage array carries no reset
   always_ff @(posedge clk) begin
      if (do_wr && !clr) mem[wp] <= wdata;
   end
endmodule

// File: rtl/vga_frame_checker.sv
// vga_frame_checker: compares view-area VGA pixels against an expected stream; optional mismatch log under VGA_CHECK_LOG_EN
module vga_frame_checker import vga_check_pkg::*; #(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CH_WIDTH = DEF_CH_WIDTH,
   parameter int XY_WIDTH = DEF_XY_WIDTH,
   parameter int VIEW_LEFT = DEF_VIEW_LEFT,
   parameter int VIEW_RIGHT = DEF_VIEW_RIGHT,
   parameter int VIEW_TOP = DEF_VIEW_TOP,
   parameter int VIEW_BOTTOM = DEF_VIEW_BOTTOM,
   parameter int MAX_MISMATCHES = DEF_MAX_MISMATCHES,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
`ifdef VGA_CHECK_LOG_EN
   , parameter int LOG_DEPTH = DEF_LOG_DEPTH
`endif
) (
   input  logic                       Clock_50,
   input  logic                       Resetn,
   input  logic                       Start_i,
   input  logic                       Vsync_n_i,
   input  logic                       Pixel_en_i,
   input  logic [XY_WIDTH-1:0]        Pixel_X_i,
   input  logic [XY_WIDTH-1:0]        Pixel_Y_i,
   input  logic [NUM_CH*CH_WIDTH-1:0] Dut_pixel_i,
   input  logic [NUM_CH*CH_WIDTH-1:0] Exp_pixel_i,
   input  logic                       Exp_valid_i,
   output logic                       Exp_ready_o,
   output logic                       Busy_o,
   output logic                       Done_o,
   output logic                       Pass_o,
   output logic                       Abort_o,
   output logic                       Underrun_o,
   output logic [CNT_WIDTH-1:0]       Mismatch_count_o,
   output logic [CNT_WIDTH-1:0]       Pixel_count_o,
   output logic [XY_WIDTH-1:0]        First_err_x_o,
   output logic [XY_WIDTH-1:0]        First_err_y_o,
   output logic [NUM_CH-1:0]          First_err_mask_o
`ifdef VGA_CHECK_LOG_EN
   ,
   input  logic                       Log_rd_i,
   output logic                       Log_empty_o,
   output logic [2*XY_WIDTH+NUM_CH-1:0] Log_data_o
`endif
);
   localparam int PCW = $clog2(NUM_CH + 1);
   localparam logic [CNT_WIDTH-1:0] FULL_PIX = CNT_WIDTH'((VIEW_RIGHT - VIEW_LEFT) * (VIEW_BOTTOM - VIEW_TOP));
   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_MISMATCHES);
   state_t state, state_nxt;
   logic in_view, hit, abort_hit;
   logic [NUM_CH-1:0] bad;
   logic [PCW-1:0] nbad;
   logic [CNT_WIDTH:0] msum;
   logic [CNT_WIDTH-1:0] mcnt, mcnt_nxt, pcnt, pcnt_nxt;
   logic abort_flag, underrun_flag;
   logic [XY_WIDTH-1:0] first_x, first_y;
   logic [NUM_CH-1:0] first_mask;
   assign in_view = (Pixel_X_i >= XY_WIDTH'(VIEW_LEFT)) && (Pixel_X_i < XY_WIDTH'(VIEW_RIGHT)) &&
                    (Pixel_Y_i >= XY_WIDTH'(VIEW_TOP)) && (Pixel_Y_i < XY_WIDTH'(VIEW_BOTTOM));
   assign hit = (state == S_CHECK) & Pixel_en_i & in_view;
   assign Exp_ready_o = hit;
   // per-channel compare; a missing expected word fails every channel
   always_comb begin
      bad = '0;
      nbad = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         bad[i] = hit & (~Exp_valid_i | (Dut_pixel_i[i*CH_WIDTH +: CH_WIDTH] != Exp_pixel_i[i*CH_WIDTH +: CH_WIDTH]));
         nbad = nbad + PCW'(bad[i]);
      end
   end
   assign msum = {1'b0, mcnt} + (CNT_WIDTH+1)'(nbad);
   assign mcnt_nxt = msum[CNT_WIDTH] ? '1 : msum[CNT_WIDTH-1:0];
   assign pcnt_nxt = (hit && !(&pcnt)) ? pcnt + CNT_WIDTH'(1) : pcnt;
   assign abort_hit = (MAX_MISMATCHES != 0) && (mcnt_nxt > MAX_CNT);
   // frame sequencing; a start pulse re-arms from any state
   always_comb begin
      state_nxt = state;
      case (state)
         S_ARMED: state_nxt = !Vsync_n_i ? S_SYNC : S_ARMED;
         S_SYNC:  state_nxt = Vsync_n_i ? S_CHECK : S_SYNC;
         S_CHECK: state_nxt = (abort_hit || !Vsync_n_i) ? S_DONE : S_CHECK;
         default: state_nxt = state;
      endcase
      if (Start_i) state_nxt = S_ARMED;
   end
   // state, counters, sticky flags and first-failure capture
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state <= S_IDLE;
         mcnt <= '0;
         pcnt <= '0;
         abort_flag <= 1'b0;
         underrun_flag <= 1'b0;
         first_x <= '0;
         first_y <= '0;
         first_mask <= '0;
      end else begin
         state <= state_nxt;
         if (Start_i) begin
            mcnt <= '0;
            pcnt <= '0;
            abort_flag <= 1'b0;
            underrun_flag <= 1'b0;
            first_x <= '0;
            first_y <= '0;
            first_mask <= '0;
         end else begin
            mcnt <= mcnt_nxt;
            pcnt <= pcnt_nxt;
            if (hit && !Exp_valid_i) underrun_flag <= 1'b1;
            if (state == S_CHECK && abort_hit) abort_flag <= 1'b1;
            if (|bad && first_mask == '0) begin
               first_x <= Pixel_X_i;
               first_y <= Pixel_Y_i;
               first_mask <= bad;
            end
         end
      end
   end
   assign Busy_o = (state == S_ARMED) | (state == S_SYNC) | (state == S_CHECK);
   assign Done_o = state == S_DONE;
   assign Pass_o = Done_o & ~abort_flag & ~underrun_flag & (mcnt == '0) & (pcnt == FULL_PIX);
   assign Abort_o = abort_flag;
   assign Underrun_o = underrun_flag;
   assign Mismatch_count_o = mcnt;
   assign Pixel_count_o = pcnt;
   assign First_err_x_o = first_x;
   assign First_err_y_o = first_y;
   assign First_err_mask_o = first_mask;
`ifdef VGA_CHECK_LOG_EN
   mismatch_log_fifo #(
      .WIDTH(2*XY_WIDTH + NUM_CH),
      .DEPTH(LOG_DEPTH)
   ) u_log (
      .clk(Clock_50),
      .rst_n(Resetn),
      .clr(Start_i),
      .wr(|bad),
      .wdata({Pixel_Y_i, Pixel_X_i, bad}),
      .rd(Log_rd_i),
      .rdata(Log_data_o),
      .empty(Log_empty_o)
   );
`endif
endmodule

// File: tb/tb_vga_frame_checker.sv
// tb_vga_frame_checker: directed and randomized frames against a scan-order reference model
module tb_vga_frame_checker;
   localparam int NC = 3, CW = 8, XW = 10, PW = NC*CW;
   localparam int VL = 4, VR = 12, VT = 2, VB = 8, MAXM = 10, CNTW = 20, LD = 8;
   localparam int W = 16, H = 10, VIEWN = (VR-VL)*(VB-VT);
   typedef struct {int cnt; int pix; int fx; int fy; int fm; int abrt; int undr; int pass;} res_t;
   logic clk = 0, rst_n = 0, start = 0, vsync_n = 1, pix_en = 0, exp_valid = 0;
   logic [XW-1:0] px = '0, py = '0;
   logic [PW-1:0] dut_pixel = '0, exp_pixel = '0;
   logic exp_ready, busy, done, pass, abort_f, underrun;
   logic [CNTW-1:0] mcount, pcount;
   logic [XW-1:0] ex, ey;
   logic [NC-1:0] emask;
`ifdef VGA_CHECK_LOG_EN
   logic log_rd = 0, log_empty;
   logic [2*XW+NC-1:0] log_data;
`endif
   int vectors = 0, errors = 0;
   logic [PW-1:0] dpx [H][W];
   logic [PW-1:0] epx [H][W];
   bit und [H][W];
   always #5 clk = ~clk;
   vga_frame_checker #(
      .NUM_CH(NC), .CH_WIDTH(CW), .XY_WIDTH(XW), .VIEW_LEFT(VL), .VIEW_RIGHT(VR),
      .VIEW_TOP(VT), .VIEW_BOTTOM(VB), .MAX_MISMATCHES(MAXM), .CNT_WIDTH(CNTW)
`ifdef VGA_CHECK_LOG_EN
      , .LOG_DEPTH(LD)
`endif
   ) dut (
      .Clock_50(clk), .Resetn(rst_n), .Start_i(start), .Vsync_n_i(vsync_n), .Pixel_en_i(pix_en),
      .Pixel_X_i(px), .Pixel_Y_i(py), .Dut_pixel_i(dut_pixel), .Exp_pixel_i(exp_pixel),
      .Exp_valid_i(exp_valid), .Exp_ready_o(exp_ready), .Busy_o(busy), .Done_o(done), .Pass_o(pass),
      .Abort_o(abort_f), .Underrun_o(underrun), .Mismatch_count_o(mcount), .Pixel_count_o(pcount),
      .First_err_x_o(ex), .First_err_y_o(ey), .First_err_mask_o(emask)
`ifdef VGA_CHECK_LOG_EN
      , .Log_rd_i(log_rd), .Log_empty_o(log_empty), .Log_data_o(log_data)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic zero_check(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_abort"}, 32'(abort_f), 0);
      chk({tag, "_underrun"}, 32'(underrun), 0);
      chk({tag, "_mcount"}, 32'(mcount), 0);
      chk({tag, "_pcount"}, 32'(pcount), 0);
      chk({tag, "_ferr"}, 32'({ey, ex, emask}), 0);
      chk({tag, "_ready"}, 32'(exp_ready), 0);
   endtask
   // fresh random picture whose expected stream matches it exactly
   task automatic fill();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            dpx[y][x] = PW'($urandom);
            epx[y][x] = dpx[y][x];
            und[y][x] = 0;
         end
   endtask
   function automatic bit in_view(int x, int y);
      return x >= VL && x < VR && y >= VT && y < VB;
   endfunction
   // walk the view area in raster order: count failing channels, stop once past the threshold
   function automatic res_t model(input int rows);
      res_t r = '{default: 0};
      for (int y = VT; y < VB && y < rows; y++)
         for (int x = VL; x < VR; x++) begin
            int m = 0;
            if (r.abrt) continue;
            for (int c = 0; c < NC; c++)
               if (und[y][x] || dpx[y][x][c*CW +: CW] != epx[y][x][c*CW +: CW]) begin
                  m |= 1 << c;
                  r.cnt++;
               end
            r.pix++;
            if (und[y][x]) r.undr = 1;
            if (m != 0 && r.fm == 0) begin
               r.fx = x;
               r.fy = y;
               r.fm = m;
            end
            if (r.cnt > MAXM) r.abrt = 1;
         end
      r.pass = (!r.abrt && !r.undr && r.cnt == 0 && r.pix == VIEWN) ? 1 : 0;
      return r;
   endfunction
   // arm, sync, scan `rows` lines with random idle gaps, end frame by vsync; rst_at = view pixel index for mid-frame reset
   task automatic play(input string tag, input int rows, input int rst_at, output res_t r);
      logic [PW-1:0] q[$];
      int qi = 0, n = 0;
      bit v;
      r = model(rows);
      for (int y = VT; y < VB; y++)
         for (int x = VL; x < VR; x++)
            if (!und[y][x]) q.push_back(epx[y][x]);
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0; vsync_n = 0;
      repeat (3) @(posedge clk);
      #1 vsync_n = 1;
      @(posedge clk);
      for (int y = 0; y < rows; y++)
         for (int x = 0; x < W; x++) begin
            v = in_view(x, y);
            if ($urandom_range(3) == 0) begin
               #1 pix_en = 0; exp_valid = 0;
               @(posedge clk);
            end
            #1;
            if (v && n == rst_at) begin
               rst_n = 0;
               #1 zero_check({tag, "_midreset"});
               rst_n = 1;
               pix_en = 0;
               exp_valid = 0;
               return;
            end
            px = XW'(x);
            py = XW'(y);
            pix_en = 1;
            dut_pixel = dpx[y][x];
            exp_valid = v ? !und[y][x] : 1'($urandom_range(1));
            exp_pixel = (v && exp_valid && qi < q.size()) ? q[qi] : PW'($urandom);
            #1 chk({tag, "_ready"}, 32'(exp_ready), (v && n < r.pix) ? 1 : 0);
            if (exp_ready && exp_valid) qi++;
            if (v) n++;
            @(posedge clk);
         end
      #1 pix_en = 0; exp_valid = 0; vsync_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_pass"}, 32'(pass), r.pass);
      chk({tag, "_abort"}, 32'(abort_f), r.abrt);
      chk({tag, "_underrun"}, 32'(underrun), r.undr);
      chk({tag, "_mcount"}, 32'(mcount), r.cnt);
      chk({tag, "_pcount"}, 32'(pcount), r.pix);
      chk({tag, "_ferr_x"}, 32'(ex), r.fx);
      chk({tag, "_ferr_y"}, 32'(ey), r.fy);
      chk({tag, "_ferr_mask"}, 32'(emask), r.fm);
      vsync_n = 1;
   endtask
   initial begin
      res_t r;
      repeat (3) @(posedge clk);
      #1 zero_check("reset");
      rst_n = 1;
      fill();
      play("perfect", H, -1, r);
      chk("perfect_pass_const", 32'(pass), 1);
      chk("perfect_pix_const", 32'(pcount), VIEWN);
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      chk("rearm_busy", 32'(busy), 1);
      chk("rearm_done", 32'(done), 0);
      chk("rearm_pcount", 32'(pcount), 0);
      fill();
      epx[4][6][2*CW +: CW] = dpx[4][6][2*CW +: CW] ^ 8'h5a;
      play("red", H, -1, r);
      chk("red_count_const", 32'(mcount), 1);
      chk("red_ferr_const", 32'({ey, ex, emask}), {10'd4, 10'd6, 3'b100});
      chk("red_abort_const", 32'(abort_f), 0);
      fill();
      for (int y = VT; y < VB; y++)
         for (int x = VL; x < VR; x++)
            epx[y][x] = ~dpx[y][x];
      play("abort", H, -1, r);
      chk("abort_const", 32'(abort_f), 1);
      chk("abort_count_const", 32'(mcount), 12);
      chk("abort_pix_const", 32'(pcount), 4);
      fill();
      und[3][7] = 1;
      play("underrun", H, -1, r);
      chk("underrun_count_const", 32'(mcount), 3);
      chk("underrun_pass_const", 32'(pass), 0);
      fill();
      play("short", 5, -1, r);
      chk("short_pass_const", 32'(pass), 0);
      fill();
      play("rst", H, 13, r);
      @(posedge clk);
      #1 zero_check("after_rst");
      fill();
      play("clean", H, -1, r);
      chk("clean_pass_const", 32'(pass), 1);
      for (int k = 0; k < 6; k++) begin
         fill();
         for (int y = VT; y < VB; y++)
            for (int x = VL; x < VR; x++) begin
               int c = $urandom_range(NC-1);
               if ($urandom_range(29) == 0) epx[y][x][c*CW +: CW] = ~dpx[y][x][c*CW +: CW];
               if ($urandom_range(59) == 0) und[y][x] = 1;
            end
         play($sformatf("rand%0d", k), $urandom_range(H, 6), -1, r);
      end
`ifdef VGA_CHECK_LOG_EN
      fill();
      for (int i = 0; i < 11; i++) epx[VT + i/8][VL + i%8][CW +: CW] = ~dpx[VT + i/8][VL + i%8][CW +: CW];
      play("log", H, -1, r);
      for (int i = 0; i < LD; i++) begin
         #1 log_rd = 1;
         @(posedge clk);
         #1 log_rd = 0;
         chk($sformatf("log_entry%0d", i), 32'(log_data), 32'({10'(VT), 10'(VL + i), 3'b010}));
      end
      chk("log_empty", 32'(log_empty), 1);
      #1 log_rd = 1;
      @(posedge clk);
      #1 log_rd = 0;
      chk("log_empty_after_rd", 32'(log_empty), 1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
